spmi_capture: RTL and testbench

Front-end capture stage for the SPMI sniffer, sitting directly upstream of the packet FIFO. It synchronises the free-running SPMI clock and data pins into the system clock domain and detects the Sequence Start Condition (SSC). It then shifts bus bits MSB-first into 16-bit words and presents each word to the FIFO writer on a valid/fetched handshake. It also reports an in-sequence flag (`ssc_det`) and a sticky overflow when a word is lost.

---
 rtl/spmi_pkg.sv | 15 +
 rtl/sync_edge.sv | 38 +++
 rtl/spmi_capture.sv | 157 +++++++++++++++
 tb/tb_spmi_capture.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spmi_pkg.sv
// Shared definitions for the SPMI sniffer front end: word width, FSM states
// and default idle timeout.
package spmi_pkg;

  localparam int SPMI_WORD_W     = 16;
  localparam int BITCNT_W        = $clog2(SPMI_WORD_W) + 1;
  localparam int DEF_IDLE_CYCLES = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SSC_HI = 2'd1,
    SHIFT  = 2'd2
  } state_e;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, with single-cycle rise and
// fall strobes taken from the synchronised level and one extra history flop.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spmi_capture.sv
// SPMI capture stage: synchronises SCLK/SDATA, detects the Sequence Start
// Condition and packs bus bits MSB-first into words on a valid/fetched handshake.
module spmi_capture
  import spmi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int IDLE_CYCLES = DEF_IDLE_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   spmiclkin,
  input  logic                   spmidatin,
  output logic [SPMI_WORD_W-1:0] packet,
  output logic                   valid,
  input  logic                   fetched,
  output logic                   ssc_det,
  output logic                   overflow
);

  localparam int                IDLE_W   = $clog2(IDLE_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_CYCLES);
  localparam logic [BITCNT_W-1:0] LAST_BIT = BITCNT_W'(SPMI_WORD_W - 1);

  logic sck_lvl, sck_rise, sck_fall;
  logic sd_lvl, sd_rise, sd_fall;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (spmiclkin),
    .level (sck_lvl),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sd (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (spmidatin),
    .level (sd_lvl),
    .rise  (sd_rise),
    .fall  (sd_fall)
  );

  state_e                 state_q, state_d;
  logic [BITCNT_W-1:0]    bitcnt_q, bitcnt_d;
  logic [SPMI_WORD_W-1:0] shreg_q, shreg_d;
  logic [IDLE_W-1:0]      idle_cnt_q, idle_cnt_d;
  logic [SPMI_WORD_W-1:0] packet_q, packet_d;
  logic                   valid_q, valid_d;
  logic                   ssc_det_q, ssc_det_d;
  logic                   overflow_q, overflow_d;

  logic                   timeout;
  logic                   emit;
  logic [SPMI_WORD_W-1:0] emit_word;

  // NOTE: every variable assigned in this block gets a default first, so no
  // path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    bitcnt_d   = bitcnt_q;
    shreg_d    = shreg_q;
    idle_cnt_d = idle_cnt_q;
    packet_d   = packet_q;
    valid_d    = valid_q;
    ssc_det_d  = ssc_det_q;
    overflow_d = overflow_q;
    emit       = 1'b0;
    emit_word  = '0;
    timeout    = (idle_cnt_q == IDLE_MAX);

    if (state_q == IDLE || sck_rise || sck_fall) begin
      idle_cnt_d = '0;
    end else if (!timeout) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (sd_rise && !sck_lvl) state_d = SSC_HI;
      end
      SSC_HI: begin
        if (timeout || sck_rise) begin
          state_d = IDLE;
        end else if (sd_fall && !sck_lvl) begin
          state_d   = SHIFT;
          ssc_det_d = 1'b1;
          bitcnt_d  = '0;
          shreg_d   = '0;
        end
      end
      SHIFT: begin
        if (timeout) begin
          // A partial word is flushed left-justified so its first bit stays at the MSB.
          if (bitcnt_q != '0) begin
            emit      = 1'b1;
            emit_word = shreg_q << (SPMI_WORD_W - int'(bitcnt_q));
          end
          bitcnt_d  = '0;
          ssc_det_d = 1'b0;
          state_d   = IDLE;
        end else if (sck_fall) begin
          shreg_d = {shreg_q[SPMI_WORD_W-2:0], sd_lvl};
          if (bitcnt_q == LAST_BIT) begin
            emit      = 1'b1;
            emit_word = shreg_d;
            bitcnt_d  = '0;
          end else begin
            bitcnt_d = bitcnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A fetch in the emit cycle frees the slot, so the new word replaces the old.
    if (emit) begin
      if (!valid_q || fetched) begin
        packet_d = emit_word;
        valid_d  = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (fetched) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bitcnt_q   <= '0;
      shreg_q    <= '0;
      idle_cnt_q <= '0;
      packet_q   <= '0;
      valid_q    <= 1'b0;
      ssc_det_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitcnt_q   <= bitcnt_d;
      shreg_q    <= shreg_d;
      idle_cnt_q <= idle_cnt_d;
      packet_q   <= packet_d;
      valid_q    <= valid_d;
      ssc_det_q  <= ssc_det_d;
      overflow_q <= overflow_d;
    end
  end

  assign packet   = packet_q;
  assign valid    = valid_q;
  assign ssc_det  = ssc_det_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_spmi_capture.sv
// Directed bench for spmi_capture: hand-computed words go into a scoreboard
// queue and a monitor compares every word the DUT presents.
`timescale 1ns/1ps
module tb_spmi_capture;
  import spmi_pkg::*;

  localparam int SYNC  = 2;
  localparam int IDLEC = 64;
  localparam int HOLD  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        spmiclkin;
  logic        spmidatin;
  logic [15:0] packet;
  logic        valid;
  logic        fetched;
  logic        ssc_det;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];

  always #6 clk = ~clk;

  spmi_capture #(.SYNC_STAGES(SYNC), .IDLE_CYCLES(IDLEC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spmiclkin (spmiclkin),
    .spmidatin (spmidatin),
    .packet    (packet),
    .valid     (valid),
    .fetched   (fetched),
    .ssc_det   (ssc_det),
    .overflow  (overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // A new word is on the bus when valid rises, or stays high across a fetch.
  initial begin : monitor
    logic prev_valid = 1'b0;
    logic prev_fetched = 1'b0;
    logic [15:0] exp_w;
    forever begin
      @(negedge clk);
      if (valid === 1'b1 && (!prev_valid || prev_fetched)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", {16'h0, packet}, 32'hFFFF_FFFF);
        end else begin
          exp_w = exp_q.pop_front();
          check("word", {16'h0, packet}, {16'h0, exp_w});
        end
      end
      prev_valid   = valid;
      prev_fetched = fetched;
    end
  end

  task automatic send_ssc();
    spmiclkin = 1'b0;
    spmidatin = 1'b0;
    tick(HOLD);
    spmidatin = 1'b1;
    tick(HOLD);
    spmidatin = 1'b0;
    tick(HOLD);
  endtask

  // Data changes with SCLK rising and is sampled on the following SCLK fall.
  task automatic send_bit(input logic b, input logic fetch_now);
    spmidatin = b;
    spmiclkin = 1'b1;
    tick(HOLD);
    spmiclkin = 1'b0;
    if (fetch_now) begin
      tick(SYNC);
      fetched = 1'b1;
      tick(1);
      fetched = 1'b0;
      tick(HOLD - SYNC - 1);
    end else begin
      tick(HOLD);
    end
  endtask

  task automatic send_bits(input logic [15:0] w, input int n, input logic fetch_last);
    for (int i = n - 1; i >= 0; i--) send_bit(w[i], fetch_last && (i == 0));
  endtask

  task automatic fetch_pulse();
    fetched = 1'b1;
    tick(1);
    fetched = 1'b0;
    tick(1);
  endtask

  task automatic consume_after3();
    int found = 0;
    int run = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (valid) begin
        found = 1;
        break;
      end
    end
    check("t1_valid_seen", found, 1);
    if (found != 0) begin
      run = 1;
      @(posedge clk);
      @(negedge clk);
      if (valid) run++;
      @(posedge clk);
      #1 fetched = 1'b1;
      @(negedge clk);
      if (valid) run++;
      @(posedge clk);
      #1 fetched = 1'b0;
      @(negedge clk);
      if (valid) run++;
      check("t1_valid_cycles", run, 3);
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin : stim
    int found;
    logic last_ssc;

    rst_n     = 1'b0;
    spmiclkin = 1'b0;
    spmidatin = 1'b0;
    fetched   = 1'b0;
    tick(3);
    check("rst_packet", {16'h0, packet}, 32'h0);
    check("rst_valid", valid, 0);
    check("rst_ssc_det", ssc_det, 0);
    check("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    tick(2);

    // T1: full word, consumer fetches three cycles after valid.
    send_ssc();
    exp_q.push_back(16'hA5C3);
    fork
      send_bits(16'hA5C3, 16, 1'b0);
      consume_after3();
    join
    check("t1_ssc_det", ssc_det, 1);
    tick(IDLEC + 10);
    check("t1_ssc_det_cleared", ssc_det, 0);

    // T2: 13-bit partial word flushed by the idle timeout.
    send_ssc();
    exp_q.push_back(16'hB658);
    send_bits(16'h16CB, 13, 1'b0);
    found    = 0;
    last_ssc = ssc_det;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (valid) begin
        found = 1;
        break;
      end
      last_ssc = ssc_det;
    end
    check("t2_flush_seen", found, 1);
    check("t2_ssc_before_flush", last_ssc, 1);
    check("t2_ssc_at_flush", ssc_det, 0);
    check("t2_fsm_idle", 32'(dut.state_q), 32'(IDLE));
    tick(1);
    fetch_pulse();

    // T5: aborted SSC (SCLK rises first), then a proper one.
    spmiclkin = 1'b0;
    spmidatin = 1'b1;
    tick(HOLD);
    spmiclkin = 1'b1;
    tick(HOLD);
    spmiclkin = 1'b0;
    tick(HOLD);
    spmidatin = 1'b0;
    tick(IDLEC + 10);
    check("t5_no_ssc", ssc_det, 0);
    check("t5_no_valid", valid, 0);
    send_ssc();
    exp_q.push_back(16'h3C5A);
    send_bits(16'h3C5A, 16, 1'b0);
    check("t5_ssc_det", ssc_det, 1);
    tick(IDLEC + 10);
    fetch_pulse();

    // T3: two words, never fetched; the second is dropped.
    send_ssc();
    exp_q.push_back(16'h1234);
    send_bits(16'h1234, 16, 1'b0);
    send_bits(16'hFEDC, 16, 1'b0);
    check("t3_overflow", overflow, 1);
    check("t3_packet_held", {16'h0, packet}, 32'h1234);
    check("t3_valid_held", valid, 1);
    tick(IDLEC + 10);

    // T6: reset after 9 bits, then bits with no SSC.
    send_ssc();
    send_bits(16'h01AB, 9, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_packet", {16'h0, packet}, 32'h0);
    check("t6_valid", valid, 0);
    check("t6_ssc_det", ssc_det, 0);
    check("t6_overflow", overflow, 0);
    spmiclkin = 1'b0;
    spmidatin = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(3);
    send_bits(16'hC3A5, 16, 1'b0);
    spmidatin = 1'b0;
    tick(IDLEC + 10);
    check("t6_no_valid", valid, 0);
    check("t6_no_ssc", ssc_det, 0);

    // T4: second word completes in the same cycle as a fetch.
    send_ssc();
    exp_q.push_back(16'h0F0F);
    exp_q.push_back(16'h8001);
    send_bits(16'h0F0F, 16, 1'b0);
    send_bits(16'h8001, 16, 1'b1);
    check("t4_packet", {16'h0, packet}, 32'h8001);
    check("t4_valid", valid, 1);
    check("t4_overflow", overflow, 0);
    tick(IDLEC + 10);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
